// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the clk_div_tap_gen block.
//
// Contents:
//   DEF_CNT_W / DEF_PRE_W / DEF_SEL_W : default widths (cfg_t is sized from these)
//   op_e      : tap combine operation (AND, OR, XOR, NAND)
//   state_e   : control FSM states (IDLE, RUN, PEND)
//   cfg_t     : one configuration word {pre, sel_a, sel_b, op}
//   CFG_RESET : configuration loaded at reset
//   apply_op  : evaluates op_e on two tap bits
//
// Optional feature macro used elsewhere in this block: CLK_DIV_EDGE_EN.

package clk_div_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_PRE_W = 4;
    localparam int DEF_SEL_W = $clog2(DEF_CNT_W);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_PRE_W-1:0] pre;
        logic [DEF_SEL_W-1:0] sel_a;
        logic [DEF_SEL_W-1:0] sel_b;
        op_e                  op;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        pre:   '0,
        sel_a: '0,
        sel_b: DEF_SEL_W'(1),
        op:    OP_AND
    };

    function automatic logic apply_op(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/clk_div_prescaler.sv
// clk_div_prescaler: programmable prescaler for clk_div_tap_gen.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   clr     in   force the prescaler count to 0 (takes priority over en)
//   en      in   advance the prescaler this cycle; 0 holds the count
//   pre     in   prescale value P; a hit occurs every P+1 enabled cycles
//   hit     out  combinational: count has reached P this cycle
//   tick    out  registered one-cycle strobe following a hit
//
// The tick register is cleared whenever the prescaler is not advancing so a
// strobe can never reappear after a freeze.

module clk_div_prescaler
    import clk_div_pkg::*;
#(
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] pre,
    output logic             hit,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    assign hit = (pre_cnt == pre);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (clr) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (en) begin
            if (hit) begin
                pre_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_tap_gen.sv
// clk_div_tap_gen: synchronous tap generator replacing the ripple divider
// chain that feeds the output pin mux.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   ena        in   design enable; 0 freezes every register
//   run        in   1 = count, 0 = return to IDLE
//   cfg_valid  in   configuration offer
//   cfg_ready  out  configuration accept
//   cfg_pre    in   prescale value P (tick every P+1 cycles)
//   cfg_sel_a  in   tap index A
//   cfg_sel_b  in   tap index B
//   cfg_op     in   00 AND, 01 OR, 10 XOR, 11 NAND
//   taps       out  counter bits; taps[i] period = 2^(i+1)*(P+1) cycles
//   y          out  registered op(taps[A], taps[B])
//   tick       out  one-cycle prescaler strobe
//   wrap       out  one-cycle strobe on counter rollover all-ones -> 0
//   busy       out  state != IDLE
//   y_rise     out  (only with CLK_DIV_EDGE_EN) pulse the cycle after y rises
//
// Optional feature macro: CLK_DIV_EDGE_EN.
//
// A configuration accepted while counting is parked in a pending slot and
// only becomes active on the counter rollover, so tap waveforms never
// change cadence mid-period.

module clk_div_tap_gen
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     run,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [PRE_W-1:0]         cfg_pre,
    input  logic [$clog2(CNT_W)-1:0] cfg_sel_a,
    input  logic [$clog2(CNT_W)-1:0] cfg_sel_b,
    input  logic [1:0]               cfg_op,
    output logic [CNT_W-1:0]         taps,
    output logic                     y,
    output logic                     tick,
    output logic                     wrap,
    output logic                     busy
`ifdef CLK_DIV_EDGE_EN
    ,
    output logic                     y_rise
`endif
);

    state_e           state;
    state_e           state_nxt;
    cfg_t             active_cfg;
    cfg_t             pending_cfg;
    cfg_t             cfg_in;
    logic [CNT_W-1:0] cnt;
    logic             y_r;
    logic             wrap_r;
    logic             tick_r;
    logic             hit;
    logic             count_en;
    logic             wrap_now;
    logic             handshake;
    logic             load_active;
    logic             load_pending;
    logic             promote;

    assign cfg_in = '{
        pre:   cfg_pre,
        sel_a: cfg_sel_a,
        sel_b: cfg_sel_b,
        op:    op_e'(cfg_op)
    };

    // Counting happens only in RUN/PEND with run still high; any other
    // enabled cycle clears the counters.
    assign count_en  = ena && run && (state != IDLE);
    assign wrap_now  = count_en && hit && (cnt == '1);
    assign handshake = cfg_valid && cfg_ready;

    clk_div_prescaler #(
        .PRE_W(PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ena && !count_en),
        .en    (count_en),
        .pre   (active_cfg.pre),
        .hit   (hit),
        .tick  (tick_r)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cfg_ready    = 1'b0;
        load_active  = 1'b0;
        load_pending = 1'b0;
        promote      = 1'b0;
        if (ena) begin
            case (state)
                IDLE: begin
                    cfg_ready   = 1'b1;
                    load_active = handshake;
                    if (run) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    cfg_ready = 1'b1;
                    // A handshake coinciding with run falling is dropped.
                    if (!run) begin
                        state_nxt = IDLE;
                    end else if (handshake) begin
                        load_pending = 1'b1;
                        state_nxt    = PEND;
                    end
                end
                PEND: begin
                    if (!run) begin
                        state_nxt = IDLE;
                    end else if (wrap_now) begin
                        promote   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_cfg  <= CFG_RESET;
            pending_cfg <= CFG_RESET;
        end else begin
            if (load_active) begin
                active_cfg <= cfg_in;
            end else if (promote) begin
                active_cfg <= pending_cfg;
            end
            if (load_pending) begin
                pending_cfg <= cfg_in;
            end
        end
    end

    // Strobe registers are cleared during a freeze so that no pulse is
    // replayed when ena returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            wrap_r <= 1'b0;
        end else if (ena) begin
            if (!count_en) begin
                cnt    <= '0;
                wrap_r <= 1'b0;
            end else begin
                wrap_r <= hit && (cnt == '1);
                if (hit) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end else begin
            wrap_r <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_r <= 1'b0;
        end else if (ena) begin
            y_r <= apply_op(active_cfg.op, cnt[active_cfg.sel_a], cnt[active_cfg.sel_b]);
        end
    end

`ifdef CLK_DIV_EDGE_EN
    logic y_d;
    logic y_rise_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_d      <= 1'b0;
            y_rise_r <= 1'b0;
        end else if (ena) begin
            y_d      <= y_r;
            y_rise_r <= y_r && !y_d;
        end else begin
            y_rise_r <= 1'b0;
        end
    end

    assign y_rise = y_rise_r && ena;
`endif

    assign taps = cnt;
    assign y    = y_r;
    assign tick = tick_r && ena;
    assign wrap = wrap_r && ena;
    assign busy = (state != IDLE);

endmodule
